// File: rtl/pe_pkg.sv
// Shared constants for the dual-mode systolic processing element.
package pe_pkg;
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 2*DEF_DATA_WIDTH + 4;
endpackage

// File: rtl/pe_sat_adder.sv
// Combinational ACC-width adder with one guard bit; flags overflow and optionally clamps.
module pe_sat_adder #(
  parameter int WIDTH    = 20,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH:0] ext_a, ext_b, raw;

  // Clamp target: the guard bit of the raw result gives the true sign of the overflowed sum.
  function automatic logic [WIDTH-1:0] sat_value(input logic negative);
    if (SIGNED != 0)
      return negative ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      return {WIDTH{1'b1}};
  endfunction

  always_comb begin
    ext_a    = {(SIGNED != 0) & a[WIDTH-1], a};
    ext_b    = {(SIGNED != 0) & b[WIDTH-1], b};
    raw      = ext_a + ext_b;
    overflow = (SIGNED != 0) ? (raw[WIDTH] ^ raw[WIDTH-1]) : raw[WIDTH];
    sum      = raw[WIDTH-1:0];
    if (overflow && (SATURATE != 0))
      sum = sat_value(raw[WIDTH]);
  end

endmodule

// File: rtl/pe_dual_mode.sv
// Systolic PE with run-time weight-stationary / output-stationary dataflow,
// double-buffered weight and saturating accumulation.
module pe_dual_mode
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + 4,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  SYNC_RST,
  input  logic                  EN,
  input  logic                  Mode,
  input  logic                  WLoad,
  input  logic                  WSwap,
  input  logic                  Drain,
  input  logic                  InValid,
  input  logic [DATA_WIDTH-1:0] Input,
  input  logic [DATA_WIDTH-1:0] Weight,
  input  logic [ACC_WIDTH-1:0]  PsumIn,
  output logic [DATA_WIDTH-1:0] ToRight,
  output logic                  ToRightValid,
  output logic [DATA_WIDTH-1:0] ToDown,
  output logic                  ToDownValid,
  output logic [ACC_WIDTH-1:0]  PsumOut,
  output logic                  PsumOutValid,
  output logic                  Overflow
);

  logic                        mode_q;
  logic [DATA_WIDTH-1:0]       shadow_p1, active_p1, mul_w_p0;
  logic signed [ACC_WIDTH-1:0] acc_p1, add_a_p0, prod_p0, sum_p0;
  logic                        ovf_p0;

  function automatic logic signed [ACC_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] x);
    logic pad;
    pad = (SIGNED != 0) & x[DATA_WIDTH-1];
    return $signed({{(ACC_WIDTH-DATA_WIDTH){pad}}, x});
  endfunction

  // ---- stage p0: operand select, multiply at accumulator width, add ----
  always_comb begin
    mul_w_p0 = (mode_q == MODE_OS) ? Weight : active_p1;
    prod_p0  = extend(Input) * extend(mul_w_p0);
    add_a_p0 = (mode_q == MODE_OS) ? acc_p1 : $signed(PsumIn);
  end

  pe_sat_adder #(
    .WIDTH   (ACC_WIDTH),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_adder (
    .a       (add_a_p0),
    .b       (prod_p0),
    .sum     (sum_p0),
    .overflow(ovf_p0)
  );

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      mode_q <= MODE_WS; shadow_p1 <= '0; active_p1 <= '0; acc_p1 <= '0;
      ToRight <= '0; ToRightValid <= 1'b0; ToDown <= '0; ToDownValid <= 1'b0;
      PsumOut <= '0; PsumOutValid <= 1'b0; Overflow <= 1'b0;
    end else if (SYNC_RST) begin
      mode_q <= MODE_WS; shadow_p1 <= '0; active_p1 <= '0; acc_p1 <= '0;
      ToRight <= '0; ToRightValid <= 1'b0; ToDown <= '0; ToDownValid <= 1'b0;
      PsumOut <= '0; PsumOutValid <= 1'b0; Overflow <= 1'b0;
    end else if (EN) begin
      if (Mode != mode_q) begin
        // Dataflow switch: flush the local sum, suppress this cycle's beats, keep weights.
        mode_q       <= Mode;
        acc_p1       <= '0;
        ToRightValid <= 1'b0;
        ToDownValid  <= 1'b0;
        PsumOutValid <= 1'b0;
      end else if (mode_q == MODE_WS) begin
        ToDownValid  <= WLoad;
        ToRightValid <= InValid;
        PsumOutValid <= InValid;
        if (WLoad) begin
          shadow_p1 <= Weight;
          ToDown    <= shadow_p1;
        end
        if (WSwap)
          active_p1 <= shadow_p1;
        if (InValid) begin
          PsumOut  <= sum_p0;
          ToRight  <= Input;
          Overflow <= Overflow | ovf_p0;
        end
      end else begin
        ToRightValid <= InValid;
        ToDownValid  <= InValid;
        PsumOutValid <= Drain;
        if (InValid) begin
          ToRight  <= Input;
          ToDown   <= Weight;
          Overflow <= Overflow | ovf_p0;
        end
        if (Drain) begin
          PsumOut <= InValid ? sum_p0 : acc_p1;
          acc_p1  <= '0;
        end else if (InValid) begin
          acc_p1 <= sum_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_dual_mode.sv
// Bench for pe_dual_mode: three parameterisations driven in lockstep against a value-level model.
module tb_pe_dual_mode;

  logic        CLK = 1'b0;
  logic        ASYNC_RST, SYNC_RST, EN, Mode, WLoad, WSwap, Drain, InValid;
  logic [7:0]  Input, Weight;
  logic [19:0] PsumIn;

  logic [7:0]  tr [3], td [3];
  logic        trv[3], tdv[3], pv[3], ov[3];
  logic [15:0] po16_0, po16_1;
  logic [19:0] po20_2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  // cfg 0: signed/saturate/16b, cfg 1: signed/wrap/16b, cfg 2: unsigned/saturate/20b
  pe_dual_mode #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u0 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .Mode(Mode),
    .WLoad(WLoad), .WSwap(WSwap), .Drain(Drain), .InValid(InValid), .Input(Input),
    .Weight(Weight), .PsumIn(PsumIn[15:0]), .ToRight(tr[0]), .ToRightValid(trv[0]),
    .ToDown(td[0]), .ToDownValid(tdv[0]), .PsumOut(po16_0), .PsumOutValid(pv[0]),
    .Overflow(ov[0]));
  pe_dual_mode #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) u1 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .Mode(Mode),
    .WLoad(WLoad), .WSwap(WSwap), .Drain(Drain), .InValid(InValid), .Input(Input),
    .Weight(Weight), .PsumIn(PsumIn[15:0]), .ToRight(tr[1]), .ToRightValid(trv[1]),
    .ToDown(td[1]), .ToDownValid(tdv[1]), .PsumOut(po16_1), .PsumOutValid(pv[1]),
    .Overflow(ov[1]));
  pe_dual_mode #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(1)) u2 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .Mode(Mode),
    .WLoad(WLoad), .WSwap(WSwap), .Drain(Drain), .InValid(InValid), .Input(Input),
    .Weight(Weight), .PsumIn(PsumIn), .ToRight(tr[2]), .ToRightValid(trv[2]),
    .ToDown(td[2]), .ToDownValid(tdv[2]), .PsumOut(po20_2), .PsumOutValid(pv[2]),
    .Overflow(ov[2]));

  // ---------------- reference model (numeric values, not bit vectors) ----------------
  int  cfg_aw [3] = '{16, 16, 20};
  bit  cfg_s  [3] = '{1'b1, 1'b1, 1'b0};
  bit  cfg_sat[3] = '{1'b1, 1'b0, 1'b1};

  logic [7:0] m_sh[3], m_act[3], m_tr[3], m_td[3];
  longint     m_acc[3], m_po[3];
  bit         m_mode[3], m_trv[3], m_tdv[3], m_pv[3], m_ov[3];

  function automatic longint mask(int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sval(longint raw, int w, bit s);
    longint v = raw & mask(w);
    if (s && ((v >> (w-1)) & 1) == 1) v = v - (longint'(1) << w);
    return v;
  endfunction

  task automatic add(input int k, input longint a, input longint b,
                     output longint r, output bit o);
    int w = cfg_aw[k];
    longint mx = cfg_s[k] ? (longint'(1) << (w-1)) - 1 : mask(w);
    longint mn = cfg_s[k] ? -(longint'(1) << (w-1)) : 0;
    longint s = a + b;
    o = (s > mx) || (s < mn);
    if (!o)              r = s;
    else if (cfg_sat[k]) r = (s > mx) ? mx : mn;
    else                 r = sval(s, w, cfg_s[k]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sh[k] = 0; m_act[k] = 0; m_tr[k] = 0; m_td[k] = 0; m_acc[k] = 0; m_po[k] = 0;
      m_mode[k] = 0; m_trv[k] = 0; m_tdv[k] = 0; m_pv[k] = 0; m_ov[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      longint prod, r;
      bit o;
      logic [7:0] old_sh;
      if (SYNC_RST) begin
        m_sh[k] = 0; m_act[k] = 0; m_tr[k] = 0; m_td[k] = 0; m_acc[k] = 0; m_po[k] = 0;
        m_mode[k] = 0; m_trv[k] = 0; m_tdv[k] = 0; m_pv[k] = 0; m_ov[k] = 0;
      end else if (EN) begin
        if (Mode != m_mode[k]) begin
          m_mode[k] = Mode; m_acc[k] = 0; m_trv[k] = 0; m_tdv[k] = 0; m_pv[k] = 0;
        end else if (!m_mode[k]) begin
          old_sh = m_sh[k];
          prod = sval(Input, 8, cfg_s[k]) * sval(m_act[k], 8, cfg_s[k]);
          add(k, sval(PsumIn, cfg_aw[k], cfg_s[k]), prod, r, o);
          m_tdv[k] = WLoad;
          if (WLoad) begin m_sh[k] = Weight; m_td[k] = old_sh; end
          if (WSwap) m_act[k] = old_sh;
          m_trv[k] = InValid; m_pv[k] = InValid;
          if (InValid) begin m_po[k] = r; m_tr[k] = Input; if (o) m_ov[k] = 1; end
        end else begin
          prod = sval(Input, 8, cfg_s[k]) * sval(Weight, 8, cfg_s[k]);
          add(k, m_acc[k], prod, r, o);
          m_trv[k] = InValid; m_tdv[k] = InValid; m_pv[k] = Drain;
          if (InValid) begin m_tr[k] = Input; m_td[k] = Weight; if (o) m_ov[k] = 1; end
          if (Drain) begin m_po[k] = InValid ? r : m_acc[k]; m_acc[k] = 0; end
          else if (InValid) m_acc[k] = r;
        end
      end
    end
  endtask

  function automatic logic [19:0] po_of(int k);
    return (k == 0) ? {4'b0, po16_0} : (k == 1) ? {4'b0, po16_1} : po20_2;
  endfunction

  function automatic logic [39:0] obs(int k);
    return {tr[k], trv[k], td[k], tdv[k], po_of(k), pv[k], ov[k]};
  endfunction

  function automatic logic [39:0] expv(int k);
    logic [19:0] p = 20'(m_po[k] & mask(cfg_aw[k]));
    return {m_tr[k], m_trv[k], m_td[k], m_tdv[k], p, m_pv[k], m_ov[k]};
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    SYNC_RST = 0; EN = 1; WLoad = 0; WSwap = 0; Drain = 0; InValid = 0;
    Input = 0; Weight = 0; PsumIn = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ASYNC_RST = 0; Mode = 0; idle(); model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== 40'd0) begin
        n_bad++; $display("FAIL reset_init k%0d: got %h want 0", k, obs(k));
      end
    end
    @(posedge CLK); #1; ASYNC_RST = 1;
    // stream a few beats, then pull reset between edges
    WLoad = 1; Weight = 8'd9; tick();
    WLoad = 0; WSwap = 1; tick();
    WSwap = 0; InValid = 1; Input = 8'd5; PsumIn = 20'd40000; tick();
    #2; ASYNC_RST = 0; #1; model_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== 40'd0) begin
        n_bad++; $display("FAIL reset_async k%0d: got %h want 0", k, obs(k));
      end
    end
    @(posedge CLK); #1; ASYNC_RST = 1; idle();
  endtask

  task automatic test_ws_chain();
    Mode = 0; idle();
    WLoad = 1; Weight = 8'd3; tick();
    Weight = 8'd5; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (td[k] !== 8'd3 || tdv[k] !== 1'b1) begin
        n_bad++; $display("FAIL ws_todown k%0d: got %0d/%b want 3/1", k, td[k], tdv[k]);
      end
    end
    idle(); WSwap = 1; tick();
    idle(); InValid = 1; Input = 8'd4; PsumIn = 20'd10; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd30 || tr[k] !== 8'd4 || pv[k] !== 1'b1 || trv[k] !== 1'b1) begin
        n_bad++; $display("FAIL ws_mac k%0d: got psum %0d right %0d v %b%b want 30 4 11",
                          k, po_of(k), tr[k], pv[k], trv[k]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_os_accumulate();
    Mode = 1; idle(); tick();
    InValid = 1;
    Input = 8'd2; Weight = 8'd3; tick();
    Input = 8'd4; Weight = 8'd5; tick();
    Input = 8'd6; Weight = 8'd7; tick();
    idle(); Drain = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd68 || pv[k] !== 1'b1) begin
        n_bad++; $display("FAIL os_drain k%0d: got %0d/%b want 68/1", k, po_of(k), pv[k]);
      end
    end
    idle(); tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (pv[k] !== 1'b0) begin
        n_bad++; $display("FAIL os_drain_pulse k%0d: got valid %b want 0", k, pv[k]);
      end
    end
    Drain = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd0 || pv[k] !== 1'b1) begin
        n_bad++; $display("FAIL os_redrain k%0d: got %0d/%b want 0/1", k, po_of(k), pv[k]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_drain_with_beat();
    idle(); InValid = 1; Input = 8'd2; Weight = 8'd5; tick();
    Input = 8'd2; Weight = 8'd3; Drain = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd16 || pv[k] !== 1'b1) begin
        n_bad++; $display("FAIL drain_beat k%0d: got %0d/%b want 16/1", k, po_of(k), pv[k]);
      end
    end
    idle(); Drain = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd0) begin
        n_bad++; $display("FAIL drain_beat_clear k%0d: got %0d want 0", k, po_of(k));
      end
    end
    idle(); tick();
  endtask

  task automatic test_saturation();
    logic [19:0] want_p[3] = '{20'd32767, 20'h08000, 20'd32768};
    logic        want_o[3] = '{1'b1, 1'b1, 1'b0};
    Mode = 0; idle(); tick();
    WLoad = 1; Weight = 8'd1; tick();
    idle(); WSwap = 1; tick();
    idle(); InValid = 1; Input = 8'd1; PsumIn = 20'd32767; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== want_p[k] || ov[k] !== want_o[k]) begin
        n_bad++; $display("FAIL sat_edge k%0d: got %h/%b want %h/%b",
                          k, po_of(k), ov[k], want_p[k], want_o[k]);
      end
    end
    PsumIn = 20'd5; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd6 || ov[k] !== want_o[k]) begin
        n_bad++; $display("FAIL sat_sticky k%0d: got %0d/%b want 6/%b",
                          k, po_of(k), ov[k], want_o[k]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_stall_clear_mode();
    logic [39:0] snap[3];
    Mode = 0; idle();
    InValid = 1; WLoad = 1; Input = 8'd7; Weight = 8'd2; PsumIn = 20'd100; tick();
    for (int k = 0; k < 3; k++) snap[k] = obs(k);
    for (int c = 0; c < 3; c++) begin
      EN = 0; InValid = 1'($urandom); WLoad = 1'($urandom); WSwap = 1'($urandom);
      Mode = 1'($urandom); Input = 8'($urandom); Weight = 8'($urandom);
      PsumIn = 20'($urandom); tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== snap[k]) begin
          n_bad++; $display("FAIL stall c%0d k%0d: got %h want %h", c, k, obs(k), snap[k]);
        end
      end
    end
    Mode = 0; idle(); SYNC_RST = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== 40'd0) begin
        n_bad++; $display("FAIL sync_clear k%0d: got %h want 0", k, obs(k));
      end
    end
    idle(); WSwap = 1; tick();
    idle(); InValid = 1; Input = 8'd3; PsumIn = 20'd7; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd7) begin
        n_bad++; $display("FAIL sync_weight k%0d: got %0d want 7", k, po_of(k));
      end
    end
    Mode = 1; idle(); tick();
    InValid = 1; Input = 8'd3; Weight = 8'd3; tick();
    Mode = 0; InValid = 1; Drain = 1; WLoad = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({trv[k], tdv[k], pv[k]} !== 3'b000 || po_of(k) !== 20'd7) begin
        n_bad++; $display("FAIL mode_toggle k%0d: got valids %b%b%b psum %0d want 000 7",
                          k, trv[k], tdv[k], pv[k], po_of(k));
      end
    end
    Mode = 1; idle(); tick();
    Drain = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (po_of(k) !== 20'd0 || pv[k] !== 1'b1) begin
        n_bad++; $display("FAIL mode_acc_clear k%0d: got %0d/%b want 0/1", k, po_of(k), pv[k]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      SYNC_RST = ($urandom_range(0, 49) == 0);
      EN       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) Mode = ~Mode;
      WLoad = 1'($urandom); WSwap = 1'($urandom); Drain = ($urandom_range(0, 3) == 0);
      InValid = ($urandom_range(0, 3) != 0);
      Input = 8'($urandom); Weight = 8'($urandom); PsumIn = 20'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++; $display("FAIL random c%0d k%0d: got %h want %h", c, k, obs(k), expv(k));
        end
      end
    end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_ws_chain();
    test_os_accumulate();
    test_drain_with_beat();
    test_saturation();
    test_stall_clear_mode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_dual_mode.md
# pe_dual_mode

Parametrised successor to the systolic-array processing element. It supports two dataflows, selectable at run time:
- **Weight-stationary (WS):** the partial sum flows down the column.
- **Output-stationary (OS):** the partial sum accumulates locally and is drained on command.

Over the current PE it adds a double-buffered weight (load the shadow while computing), signed/unsigned arithmetic, a configurable accumulator width with saturation, and valid flags on every forwarded stream. It tiles into the same 2-D array as the current PE.

## Interface
- `DATA_WIDTH`, 8: width of activation and weight.
- `ACC_WIDTH`, `2*DATA_WIDTH+4`: width of partial sum and accumulator; must be ≥ `2*DATA_WIDTH`.
- `SIGNED`, 0: 1 = two's-complement operands and sums.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = wrap.

Ports (name, direction, width, meaning):
- `CLK` in 1: clock, rising edge.
- `ASYNC_RST` in 1: reset, asynchronous, active-low.
- `SYNC_RST` in 1: synchronous clear, active-high.
- `EN` in 1: global enable; low = every register holds.
- `Mode` in 1: 0 = WS, 1 = OS; quasi-static.
- `WLoad` in 1: shift `Weight` into the shadow weight chain (WS).
- `WSwap` in 1: copy shadow weight to active weight (WS).
- `Drain` in 1: OS only; emit the accumulator and clear it.
- `InValid` in 1: `Input` (and `Weight` in OS) carries a beat.
- `Input` in `DATA_WIDTH`: activation from the left.
- `Weight` in `DATA_WIDTH`: weight from above.
- `PsumIn` in `ACC_WIDTH`: partial sum from above (WS).
- `ToRight` out `DATA_WIDTH`: forwarded activation.
- `ToRightValid` out 1: valid for `ToRight`.
- `ToDown` out `DATA_WIDTH`: forwarded weight.
- `ToDownValid` out 1: valid for `ToDown`.
- `PsumOut` out `ACC_WIDTH`: result / partial sum.
- `PsumOutValid` out 1: valid for `PsumOut`.
- `Overflow` out 1: sticky overflow flag.

## Operation
- **Priority:** `ASYNC_RST` low > `SYNC_RST` > `EN` low (hold all) > normal operation.
- **Reset (either kind):** all outputs, shadow, active weight, accumulator, and `mode_q` go to 0.
- **Product:** `Input × w`, where `w` = active weight in WS and `Weight` in OS. It is sign-extended (SIGNED=1) or zero-extended to `ACC_WIDTH`.
- **Adder:** computed at `ACC_WIDTH+1`.
  - Overflow when the result leaves the `ACC_WIDTH` range.
  - SATURATE=1: clamp to max/min (signed) or to all-ones (unsigned).
  - SATURATE=0: truncate.
  - Either way, `Overflow` is set. It is cleared only by reset.
- **WS mode:**
  - `WLoad`: shadow ← `Weight`; `ToDown` ← old shadow; `ToDownValid` = 1. Otherwise `ToDownValid` = 0.
  - `WSwap`: active ← shadow value before the edge. `WLoad` and `WSwap` together: active gets the old shadow, shadow gets the new `Weight`.
  - `InValid`: `PsumOut` ← add(`PsumIn`, product); `ToRight` ← `Input`; both valids = 1.
  - `InValid` low: both valids = 0 and data holds.
  - `Drain` is ignored.
- **OS mode:**
  - `PsumIn`, `WLoad`, and `WSwap` are ignored.
  - `InValid`: acc ← add(acc, product); `ToRight` ← `Input`; `ToDown` ← `Weight`; both valids = 1.
  - `Drain`: `PsumOut` ← acc, or add(acc, product) if `InValid` is also high; `PsumOutValid` = 1 for one cycle; acc ← 0. Without `Drain`, `PsumOutValid` = 0.
- **Mode change:** when `Mode` ≠ `mode_q` (only while `EN` is high):
  - acc ← 0 and all valids ← 0 for that cycle; no datapath update.
  - `mode_q` ← `Mode`.
  - Shadow and active weights are retained.

## Timing
- All outputs are registered. Latency is 1 cycle from input sample to `ToRight`, `ToDown`, and `PsumOut`.
- Throughput is one beat per cycle. There is no backpressure; the array controller owns scheduling.
- `EN` low freezes everything, valids included: an asserted valid stays asserted, not re-pulsed.
- Weight swap takes effect on the next cycle's multiply: a beat sampled in the same cycle as `WSwap` uses the old active weight.
- `ASYNC_RST` mid-drain discards the accumulator; no partial output.

## Structure
- Shared package `pe_pkg`: `MODE_WS` = 0 / `MODE_OS` = 1 constants, and default width constants.
- One sub-module, `pe_sat_adder` (parameters: width, SIGNED, SATURATE):
  - Combinational.
  - Inputs: two `ACC_WIDTH` operands.
  - Outputs: sum and overflow.
  - Used once; the WS and OS paths mux its operand A.
- Multiplier: behavioural, signed or unsigned per the SIGNED parameter.

## Test plan
1. **Reset:** `ASYNC_RST` pulse mid-stream → all outputs 0 asynchronously; `Overflow` = 0.
2. **WS chain:** `WLoad` with `Weight` = 3, then `WLoad` with `Weight` = 5 → `ToDown` = 3, valid. Then `WSwap`. Then `InValid`, `Input` = 4, `PsumIn` = 10 → next cycle `PsumOut` = 30, `ToRight` = 4, both valids = 1.
3. **OS accumulate:** beats (`Input`, `Weight`) = (2,3), (4,5), (6,7), then `Drain` → `PsumOut` = 68 for exactly one cycle; following drain → 0.
4. **Drain coincident with a beat:** acc = 10; `Input` = 2, `Weight` = 3, `Drain` → `PsumOut` = 16; acc = 0.
5. **Saturation:** SIGNED=1, SATURATE=1, `ACC_WIDTH` = 16; WS, active weight 1, `Input` = 1, `PsumIn` = 32767 → `PsumOut` = 32767, `Overflow` = 1, still 1 after later clean beats. With SATURATE=0 → `PsumOut` = −32768, `Overflow` = 1.
6. **Stall, clear, mode change:**
   - `EN` low for 3 cycles mid-stream → all outputs frozen.
   - `SYNC_RST` → weights, acc, and `Overflow` = 0.
   - Toggling `Mode` with acc = 9 → acc = 0, no valid emitted.
